// File: rtl/com_ctrl.sv
// Command sequencer: takes decoded packets from the decoder, configures the ADC/trigger path,
// gates streaming and requests reply packets; every downstream handshake is bounded by TIMEOUT.
module com_ctrl #(
    parameter logic [15:0] TIMEOUT    = 16'd1000,
    parameter logic [3:0]  BTYPE_CONF = 4'h1,
    parameter logic [3:0]  BTYPE_READ = 4'h2,
    parameter logic [3:0]  BTYPE_STOP = 4'h3,
    parameter logic [3:0]  BTYPE_RXD0 = 4'h4,
    parameter logic [3:0]  BTYPE_RXD1 = 4'h5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_read,
    output logic        fd_read,
    input  logic [3:0]  btype,
    input  logic [11:0] com_cmd,
    input  logic [39:0] trgg_cmd,
    output logic        fs_conf,
    input  logic        fd_conf,
    output logic [11:0] conf_cmd,
    output logic [39:0] trgg_cfg,
    output logic        run_en,
    output logic        fs_send,
    input  logic        fd_send,
    output logic [3:0]  send_type,
    output logic [7:0]  err_cnt,
    output logic [7:0]  rej_cnt
);

    typedef enum logic [5:0] {
        S_IDLE = 6'h01,
        S_WAIT = 6'h02,
        S_TAKE = 6'h04,
        S_CONF = 6'h08,
        S_SEND = 6'h10,
        S_DONE = 6'h20
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] conf_cmd_q, conf_cmd_d;
    logic [39:0] trgg_cfg_q, trgg_cfg_d;
    logic        run_en_q, run_en_d;
    logic [3:0]  send_type_q, send_type_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  rej_cnt_q, rej_cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        tmo_fire;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Fires on the last allowed cycle; a done strobe in the same cycle still wins.
    assign tmo_fire = (tmo_q == TIMEOUT - 16'd1);

    always_comb begin
        state_d     = state_q;
        conf_cmd_d  = conf_cmd_q;
        trgg_cfg_d  = trgg_cfg_q;
        run_en_d    = run_en_q;
        send_type_d = send_type_q;
        err_cnt_d   = err_cnt_q;
        rej_cnt_d   = rej_cnt_q;

        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                if (fs_read) begin
                    state_d = S_TAKE;
                end
            end
            S_TAKE: begin
                state_d = S_DONE;
                if (btype == BTYPE_CONF) begin
                    if (run_en_q) begin
                        rej_cnt_d = sat_inc(rej_cnt_q);
                    end else begin
                        conf_cmd_d = com_cmd;
                        trgg_cfg_d = trgg_cmd;
                        state_d    = S_CONF;
                    end
                end else if (btype == BTYPE_READ) begin
                    run_en_d = 1'b1;
                end else if (btype == BTYPE_STOP) begin
                    run_en_d = 1'b0;
                end else if (btype == BTYPE_RXD0 || btype == BTYPE_RXD1) begin
                    send_type_d = btype;
                    state_d     = S_SEND;
                end else begin
                    rej_cnt_d = sat_inc(rej_cnt_q);
                end
            end
            S_CONF: begin
                if (fd_conf) begin
                    send_type_d = BTYPE_CONF;
                    state_d     = S_SEND;
                end else if (tmo_fire) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_DONE;
                end
            end
            S_SEND: begin
                if (fd_send) begin
                    state_d = S_DONE;
                end else if (tmo_fire) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (!fs_read) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = 16'd0;
        end else if (state_q == S_CONF || state_q == S_SEND) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            conf_cmd_q  <= 12'd0;
            trgg_cfg_q  <= 40'd0;
            run_en_q    <= 1'b0;
            send_type_q <= 4'd0;
            err_cnt_q   <= 8'd0;
            rej_cnt_q   <= 8'd0;
            tmo_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            conf_cmd_q  <= conf_cmd_d;
            trgg_cfg_q  <= trgg_cfg_d;
            run_en_q    <= run_en_d;
            send_type_q <= send_type_d;
            err_cnt_q   <= err_cnt_d;
            rej_cnt_q   <= rej_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign fs_conf   = (state_q == S_CONF);
    assign fs_send   = (state_q == S_SEND);
    assign fd_read   = (state_q == S_DONE);
    assign conf_cmd  = conf_cmd_q;
    assign trgg_cfg  = trgg_cfg_q;
    assign run_en    = run_en_q;
    assign send_type = send_type_q;
    assign err_cnt   = err_cnt_q;
    assign rej_cnt   = rej_cnt_q;

endmodule

// File: doc/com_ctrl.md
Name: com_ctrl

Overview:
- Command sequencer between the command-packet decoder and the acquisition and reply datapaths.
- On each decoded packet (fs/fd handshake from the decoder) it latches btype and the command words, then sequences the action:
  - configure the ADC/trigger path;
  - start or stop streaming;
  - request a reply packet from the transmit path.
- Guards every downstream handshake with a timeout and keeps error and reject counters.

Parameters:
TIMEOUT, 16'd1000, max cycles spent in CONF or SEND waiting for fd before abort
BTYPE_CONF, 4'h1, btype code for config packet
BTYPE_READ, 4'h2, btype code for start streaming
BTYPE_STOP, 4'h3, btype code for stop streaming
BTYPE_RXD0, 4'h4, btype code for reply request 0
BTYPE_RXD1, 4'h5, btype code for reply request 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
fs_read  input  1  decoder has a packet ready (level, held until fd_read seen)
fd_read  output  1  packet consumed, equals (state==DONE)
btype  input  4  decoded packet type, valid while fs_read=1
com_cmd  input  12  decoded ADC config word
trgg_cmd  input  40  decoded trigger/delay config word
fs_conf  output  1  config request to ADC/trigger block, equals (state==CONF)
fd_conf  input  1  config block done
conf_cmd  output  12  latched ADC config
trgg_cfg  output  40  latched trigger config
run_en  output  1  streaming enable level
fs_send  output  1  reply request to transmit path, equals (state==SEND)
fd_send  input  1  transmit path done
send_type  output  4  type of reply being requested
err_cnt  output  8  saturating count of handshake timeouts
rej_cnt  output  8  saturating count of rejected/unknown packets

Behaviour:
- Reset values: state IDLE; conf_cmd=0, trgg_cfg=0, run_en=0, send_type=0, err_cnt=0, rej_cnt=0, tmo counter=0.
- Reset mid-operation clears everything asynchronously. fs_conf, fs_send and fd_read drop immediately.
- One-hot state encoding: IDLE=6'h01, WAIT=6'h02, TAKE=6'h04, CONF=6'h08, SEND=6'h10, DONE=6'h20. Illegal state goes to IDLE.
- IDLE -> WAIT unconditionally.
- WAIT -> TAKE when fs_read=1; otherwise stay.
- TAKE (exactly 1 cycle), decoding the btype sampled this cycle:
  - CONF with run_en=0: conf_cmd<=com_cmd, trgg_cfg<=trgg_cmd; -> CONF.
  - CONF with run_en=1: rejected; rej_cnt++; configs unchanged; -> DONE.
  - READ: run_en<=1; -> DONE. No-op if already 1.
  - STOP: run_en<=0; -> DONE. No-op if already 0.
  - RXD0/RXD1: send_type<=btype; -> SEND.
  - Any other code: rej_cnt++; -> DONE.
- CONF: fs_conf=1.
  - fd_conf=1 -> SEND with send_type<=BTYPE_CONF (acknowledge reply).
  - Timeout -> DONE, err_cnt++, no reply sent.
- SEND: fs_send=1.
  - fd_send=1 -> DONE.
  - Timeout -> DONE, err_cnt++.
- Timeout counter: 16 bit, cleared on every state change, increments while in CONF or SEND.
  - Timeout fires when counter==TIMEOUT-1 and fd is low, so the state is left after exactly TIMEOUT cycles.
  - fd arriving in the same cycle as the timeout counts as success.
- DONE: fd_read=1. -> IDLE when fs_read=0; otherwise stay.
- Minimum latency: fs_read rise to fd_read is 2 cycles (WAIT->TAKE->DONE) for READ/STOP.
- err_cnt and rej_cnt saturate at 8'hFF.
- run_en changes only in TAKE. Outputs are registered; fs_conf, fs_send and fd_read decode the state register.

Test Plan:
- After reset, hold fs_read=1 with btype=4'h2 -> fd_read=1 two cycles after WAIT samples it, run_en=1; drop fs_read -> IDLE next cycle.
- run_en=0, btype=4'h1, com_cmd=12'hA5C, trgg_cmd=40'h12_3456_789A; fd_conf after 5 cycles in CONF -> conf_cmd=12'hA5C, trgg_cfg=40'h123456789A, fs_send=1 with send_type=4'h1; fd_send -> DONE.
- run_en=1, btype=4'h1 with new com_cmd -> no fs_conf, conf_cmd unchanged, rej_cnt=1, fd_read asserted.
- btype=4'h4, fd_send never asserted, TIMEOUT=16 -> fs_send high exactly 16 cycles, err_cnt=1, then DONE.
- btype=4'h1, fd_conf asserted in the exact timeout cycle -> goes to SEND, err_cnt unchanged.
- Assert rst while in SEND, then send btype=4'hF packets 260 times -> all outputs 0 immediately after reset; rej_cnt ends saturated at 8'hFF.
